// File: rtl/backoff_retry_pkg.sv
// Shared types and constants for the backoff/retry controller and its backoff counter.
// Holds the FSM state encoding, counter widths and the exponent-to-mask helper.
package backoff_retry_pkg;

    localparam int unsigned RetryCntWidth = 8;
    localparam int unsigned LfsrWidth     = 16;
    localparam int unsigned ExpWidth      = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_BACKOFF  = 2'd3
    } state_e;

    // Mask with the low exp_i bits set; exp_i=16 yields all ones.
    function automatic logic [LfsrWidth-1:0] exp_mask(input logic [ExpWidth-1:0] exp_i);
        logic [LfsrWidth-1:0] m;
        for (int i = 0; i < LfsrWidth; i++) begin
            m[i] = (ExpWidth'(i) < exp_i);
        end
        return m;
    endfunction

endpackage

// File: rtl/exp_backoff.sv
// Randomised exponential backoff counter: set loads an LFSR draw within a window that doubles per set.
// Latency: the loaded count is visible the cycle after set; clr returns to zero immediately at the next edge.
module exp_backoff
    import backoff_retry_pkg::*;
#(
    parameter logic [LfsrWidth-1:0] Seed   = 16'hffff,
    parameter int unsigned          MaxExp = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_i,
    input  logic clr_i,
    output logic zero_o
);

    localparam logic [ExpWidth-1:0] MaxExpW = ExpWidth'(MaxExp);

    logic [LfsrWidth-1:0] r_lfsr;
    logic [LfsrWidth-1:0] r_cnt;
    logic [ExpWidth-1:0]  r_exp;
    logic [LfsrWidth-1:0] w_lfsr_nxt;
    logic [ExpWidth-1:0]  w_exp_nxt;

    // Galois LFSR x^16+x^14+x^13+x^11; free-running so draws depend on arrival time.
    assign w_lfsr_nxt = {1'b0, r_lfsr[LfsrWidth-1:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_exp_nxt  = (r_exp < MaxExpW) ? r_exp + 5'd1 : r_exp;
    assign zero_o     = (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= Seed;
            r_exp  <= '0;
            r_cnt  <= '0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            if (clr_i) begin
                r_exp <= '0;
                r_cnt <= '0;
            end else if (set_i) begin
                r_exp <= w_exp_nxt;
                r_cnt <= r_lfsr & exp_mask(w_exp_nxt);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

endmodule

// File: rtl/backoff_retry_ctrl.sv
// Retry controller: accepts one request, issues attempts downstream, retries failures after exponential backoff.
// Latency: accept->out_valid 1 cycle, response->done/err 0 cycles; holds out_valid until out_ready; optional BACKOFF_RETRY_CTRL_TIMEOUT_EN.
module backoff_retry_ctrl
    import backoff_retry_pkg::*;
#(
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          MaxRetries    = 8,
    parameter logic [LfsrWidth-1:0] Seed          = 'hffff,
    parameter int unsigned          MaxExp        = 16,
    parameter int unsigned          TimeoutCycles = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [DataWidth-1:0]     req_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DataWidth-1:0]     out_data_o,
    input  logic                     rsp_valid_i,
    input  logic                     rsp_fail_i,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic [RetryCntWidth-1:0] retry_cnt_o
);

    if (MaxRetries < 1 || MaxRetries > 255 || MaxExp < 1 || MaxExp > 16 ||
        TimeoutCycles < 1 || Seed == '0) begin : g_bad_params
        $error("backoff_retry_ctrl: parameter out of range");
    end

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [DataWidth-1:0]     r_data;
    logic [RetryCntWidth-1:0] r_retry_cnt;
    logic                     w_rsp_fire;
    logic                     w_rsp_fail;
    logic                     w_last;
    logic                     w_bo_set;
    logic                     w_bo_clr;
    logic                     w_bo_zero;
    logic                     w_accept;
    logic                     w_done;
    logic                     w_err;

`ifdef BACKOFF_RETRY_CTRL_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TimeoutCycles + 1);

    logic [ToW-1:0] r_to_cnt;
    logic           w_timeout;

    // The count restarts on every WAIT_RSP entry, so each attempt gets the full window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_ISSUE && out_ready_i) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_WAIT_RSP) begin
            r_to_cnt <= r_to_cnt + ToW'(1);
        end
    end

    assign w_timeout  = (r_state == ST_WAIT_RSP) && !rsp_valid_i &&
                        (r_to_cnt == ToW'(TimeoutCycles - 1));
    assign w_rsp_fire = rsp_valid_i || w_timeout;
    assign w_rsp_fail = rsp_fail_i || w_timeout;
`else
    assign w_rsp_fire = rsp_valid_i;
    assign w_rsp_fail = rsp_fail_i;
`endif

    assign w_last   = (r_retry_cnt == RetryCntWidth'(MaxRetries));
    assign w_accept = (r_state == ST_IDLE) && req_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (req_valid_i) w_state_nxt = ST_ISSUE;
            ST_ISSUE:    if (out_ready_i) w_state_nxt = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (w_rsp_fire) begin
                    w_state_nxt = (!w_rsp_fail || w_last) ? ST_IDLE : ST_BACKOFF;
                end
            end
            ST_BACKOFF:  if (w_bo_zero) w_state_nxt = ST_ISSUE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Responses only count in WAIT_RSP; set and clr are mutually exclusive by construction.
    always_comb begin
        req_ready_o = (r_state == ST_IDLE);
        out_valid_o = (r_state == ST_ISSUE);
        busy_o      = (r_state != ST_IDLE);
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_bo_set    = 1'b0;
        if (r_state == ST_WAIT_RSP && w_rsp_fire) begin
            w_done   = !w_rsp_fail;
            w_err    = w_rsp_fail && w_last;
            w_bo_set = w_rsp_fail && !w_last;
        end
        w_bo_clr = w_done || w_err;
    end

    assign done_o      = w_done;
    assign err_o       = w_err;
    assign out_data_o  = r_data;
    assign retry_cnt_o = r_retry_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data      <= '0;
            r_retry_cnt <= '0;
        end else if (w_accept) begin
            r_data      <= req_data_i;
            r_retry_cnt <= '0;
        end else if (w_bo_set) begin
            r_retry_cnt <= r_retry_cnt + 8'd1;
        end
    end

    exp_backoff #(
        .Seed   (Seed),
        .MaxExp (MaxExp)
    ) u_exp_backoff (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .set_i  (w_bo_set),
        .clr_i  (w_bo_clr),
        .zero_o (w_bo_zero)
    );

endmodule
